// File: rtl/lc3_dp_pkg.sv
// -----------------------------------------------------------------------------
// lc3_dp_pkg
// Shared definitions for the LC-3 style datapath blocks.
//   - LC3_DATA_W / LC3_OPC_W : default bus width and opcode field width
//   - OP_*                   : LC-3 opcode encodings (decoder and benches)
//   - opcode_of()            : extracts the opcode field from a default-width word
// Interface and RTL modules import this package with import lc3_dp_pkg::*.
// -----------------------------------------------------------------------------
package lc3_dp_pkg;

   localparam int LC3_DATA_W = 16;
   localparam int LC3_OPC_W  = 4;

   localparam logic [LC3_OPC_W-1:0] OP_BR   = 4'h0;
   localparam logic [LC3_OPC_W-1:0] OP_ADD  = 4'h1;
   localparam logic [LC3_OPC_W-1:0] OP_LD   = 4'h2;
   localparam logic [LC3_OPC_W-1:0] OP_ST   = 4'h3;
   localparam logic [LC3_OPC_W-1:0] OP_JSR  = 4'h4;
   localparam logic [LC3_OPC_W-1:0] OP_AND  = 4'h5;
   localparam logic [LC3_OPC_W-1:0] OP_LDR  = 4'h6;
   localparam logic [LC3_OPC_W-1:0] OP_STR  = 4'h7;
   localparam logic [LC3_OPC_W-1:0] OP_RTI  = 4'h8;
   localparam logic [LC3_OPC_W-1:0] OP_NOT  = 4'h9;
   localparam logic [LC3_OPC_W-1:0] OP_LDI  = 4'hA;
   localparam logic [LC3_OPC_W-1:0] OP_STI  = 4'hB;
   localparam logic [LC3_OPC_W-1:0] OP_JMP  = 4'hC;
   localparam logic [LC3_OPC_W-1:0] OP_RES  = 4'hD;
   localparam logic [LC3_OPC_W-1:0] OP_LEA  = 4'hE;
   localparam logic [LC3_OPC_W-1:0] OP_TRAP = 4'hF;

   // Opcode field of a default-width LC-3 instruction word.
   function automatic logic [LC3_OPC_W-1:0] opcode_of(input logic [LC3_DATA_W-1:0] word);
      return word[LC3_DATA_W-1 -: LC3_OPC_W];
   endfunction

endpackage

// File: rtl/data_matrix_ir_queue_if.sv
// -----------------------------------------------------------------------------
// data_matrix_ir_queue_if
// Bundle between the bus mux / control unit (master) and the IR queue (slave).
//   master drives : bus, ld_ir, ir_adv, flush
//   slave drives  : ld_ready, ir, ir_valid, opcode, count, ovf
// -----------------------------------------------------------------------------
interface data_matrix_ir_queue_if
   import lc3_dp_pkg::*;
#(
   parameter int DATA_W = LC3_DATA_W,
   parameter int DEPTH  = 4,
   parameter int OPC_W  = LC3_OPC_W
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] bus;
   logic              ld_ir;
   logic              ld_ready;
   logic              ir_adv;
   logic              flush;
   logic [DATA_W-1:0] ir;
   logic              ir_valid;
   logic [OPC_W-1:0]  opcode;
   logic [CNT_W-1:0]  count;
   logic              ovf;

   modport master (
      output bus, ld_ir, ir_adv, flush,
      input  ld_ready, ir, ir_valid, opcode, count, ovf
   );

   modport slave (
      input  bus, ld_ir, ir_adv, flush,
      output ld_ready, ir, ir_valid, opcode, count, ovf
   );

endinterface

// File: rtl/data_matrix_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// data_matrix_prefetch_fifo
// DEPTH x DATA_W synchronous FIFO with explicit occupancy count.
//   clk, rst  : clock, synchronous active-high reset
//   flush_i   : empties the FIFO (pointers and count to zero)
//   push_i    : write wdata_i at the write pointer (caller guarantees not full)
//   pop_i     : advance the read pointer (caller guarantees not empty)
//   rdata_o   : head word, valid whenever count_o != 0
//   count_o   : number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module data_matrix_prefetch_fifo
   import lc3_dp_pkg::*;
#(
   parameter  int DATA_W = LC3_DATA_W,
   parameter  int DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, rptr_q;
   logic [CNT_W-1:0]  count_q;

   // NOTE: storage is deliberately not reset; count_q alone says which entries
   // hold data, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
         if (push_i) wptr_q <= wptr_q + PTR_W'(1);
         if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/data_matrix_ir_queue.sv
// -----------------------------------------------------------------------------
// data_matrix_ir_queue
// Instruction register with a prefetch FIFO in front of it.
//   clk, rst   : clock, synchronous active-high reset
//   q (slave)  : bus/ld_ir offer a word, ld_ready = room in the FIFO,
//                ir_adv consumes the current IR, flush discards IR validity and
//                all queued words, ir/ir_valid/opcode present the instruction,
//                count = FIFO occupancy (IR excluded), ovf = sticky drop flag.
// A word offered with the IR slot free and the FIFO empty bypasses straight to
// ir; otherwise it queues, and the IR always refills from the FIFO head first
// so accepted words reach ir strictly in order.
// -----------------------------------------------------------------------------
module data_matrix_ir_queue
   import lc3_dp_pkg::*;
#(
   parameter int DATA_W = LC3_DATA_W,
   parameter int DEPTH  = 4,
   parameter int OPC_W  = LC3_OPC_W
) (
   input  logic                  clk,
   input  logic                  rst,
   data_matrix_ir_queue_if.slave q
);

   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              ovf_q, ovf_d;

   logic [DATA_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty, fifo_full;
   logic              slot_free, bypass, push, pop, drop;

   assign fifo_empty = (fifo_count == '0);
   // Fullness comes from the registered count: a pop in the same cycle does not
   // make room for the offered word.
   assign fifo_full  = (fifo_count == FULL_CNT);
   assign slot_free  = !ir_valid_q || q.ir_adv;

   // Flush suppresses every transfer in its cycle, including the drop flag.
   assign pop    = !q.flush && slot_free && !fifo_empty;
   assign bypass = !q.flush && slot_free &&  fifo_empty && q.ld_ir;
   assign push   = !q.flush && q.ld_ir && !bypass && !fifo_full;
   assign drop   = !q.flush && q.ld_ir && !bypass &&  fifo_full;

   data_matrix_prefetch_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (q.flush),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (q.bus),
      .rdata_o (fifo_head),
      .count_o (fifo_count)
   );

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      ovf_d      = ovf_q || drop;
      if (q.flush) begin
         ir_valid_d = 1'b0;
      end else if (slot_free) begin
         if (!fifo_empty) begin
            ir_d       = fifo_head;
            ir_valid_d = 1'b1;
         end else if (q.ld_ir) begin
            ir_d       = q.bus;
            ir_valid_d = 1'b1;
         end else begin
            ir_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         ovf_q      <= ovf_d;
      end
   end

   assign q.ir       = ir_q;
   assign q.ir_valid = ir_valid_q;
   assign q.opcode   = ir_q[DATA_W-1 -: OPC_W];
   assign q.count    = fifo_count;
   assign q.ld_ready = !fifo_full;
   assign q.ovf      = ovf_q;

endmodule
